// File: rtl/branch_resolve_if.sv
// Bus between the execute-stage branch resolver and its neighbours: fetch lookup,
// the resolving branch, redirect/flush outputs and statistics.
interface branch_resolve_if;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic        br_valid;
    logic [2:0]  br_funct3;
    logic [31:0] br_pc;
    logic [31:0] br_imm;
    logic        br_pred_taken;
    logic [2:0]  cmp_result;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    // Pipeline side: drives fetch PC and the resolving branch, consumes redirect/flush.
    modport master (
        output if_pc, br_valid, br_funct3, br_pc, br_imm, br_pred_taken, cmp_result,
        input  pred_taken, redirect_valid, redirect_pc, flush, br_count, mispred_count
    );

    modport slave (
        input  if_pc, br_valid, br_funct3, br_pc, br_imm, br_pred_taken, cmp_result,
        output pred_taken, redirect_valid, redirect_pc, flush, br_count, mispred_count
    );
endinterface

// File: rtl/branch_resolve.sv
// Resolves conditional branches from comparator flags, updates the 2-bit BHT,
// and issues a registered redirect plus a multi-cycle flush on mispredict.
module branch_resolve #(
    parameter int INDEX_BITS   = 6,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    branch_resolve_if.slave   bus,
    output logic [1:0]        dbg_state
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, REDIRECT = 2'd1, FLUSH = 2'd2} state_t;

    state_t      state, next_state;
    logic [3:0]  flush_cnt, next_cnt;
    logic [1:0]  bht [ENTRIES];
    logic        legal, actual, mispredict, resolve;
    logic [31:0] target_pc;
    logic [INDEX_BITS-1:0] rd_idx, wr_idx;
    logic        unused_pc_bits;

    // Comparator flags are {EQ, SL, UL}; 010/011 are not branches.
    always_comb begin
        legal  = 1'b1;
        actual = 1'b0;
        unique case (bus.br_funct3)
            3'b000:  actual =  bus.cmp_result[2];
            3'b001:  actual = ~bus.cmp_result[2];
            3'b100:  actual =  bus.cmp_result[1];
            3'b101:  actual = ~bus.cmp_result[1];
            3'b110:  actual =  bus.cmp_result[0];
            3'b111:  actual = ~bus.cmp_result[0];
            default: legal  = 1'b0;
        endcase
    end

    assign resolve    = bus.br_valid && legal && (state == IDLE);
    assign mispredict = actual != bus.br_pred_taken;
    assign target_pc  = actual ? bus.br_pc + bus.br_imm : bus.br_pc + 32'd4;

    assign rd_idx = bus.if_pc[INDEX_BITS+1:2];
    assign wr_idx = bus.br_pc[INDEX_BITS+1:2];
    assign unused_pc_bits = ^{bus.if_pc[31:INDEX_BITS+2], bus.if_pc[1:0]};

    // Read returns pre-edge contents, so same-index read/write yields the old value.
    assign bus.pred_taken = bht[rd_idx][1];

    always_comb begin
        next_state = state;
        next_cnt   = flush_cnt;
        unique case (state)
            IDLE: begin
                if (resolve && mispredict) next_state = REDIRECT;
            end
            REDIRECT: begin
                if (FLUSH_CYCLES > 1) begin
                    next_state = FLUSH;
                    next_cnt   = FLUSH_LOAD;
                end else begin
                    next_state = IDLE;
                end
            end
            FLUSH: begin
                if (flush_cnt <= 4'd1) begin
                    next_state = IDLE;
                    next_cnt   = 4'd0;
                end else begin
                    next_cnt = flush_cnt - 4'd1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            flush_cnt <= 4'd0;
        end else begin
            state     <= next_state;
            flush_cnt <= next_cnt;
        end
    end

    assign bus.redirect_valid = (state == REDIRECT);
    assign bus.flush          = (state != IDLE);
    assign dbg_state          = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.redirect_pc   <= 32'd0;
            bus.br_count      <= 32'd0;
            bus.mispred_count <= 32'd0;
        end else if (resolve) begin
            if (mispredict) bus.redirect_pc <= target_pc;
            if (bus.br_count != 32'hFFFF_FFFF) bus.br_count <= bus.br_count + 32'd1;
            if (mispredict && bus.mispred_count != 32'hFFFF_FFFF)
                bus.mispred_count <= bus.mispred_count + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) bht[i] <= 2'b01;
        end else if (resolve) begin
            if (actual && bht[wr_idx] != 2'b11)       bht[wr_idx] <= bht[wr_idx] + 2'd1;
            else if (!actual && bht[wr_idx] != 2'b00) bht[wr_idx] <= bht[wr_idx] - 2'd1;
        end
    end
endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: vector table, directed corner sequences and a
// randomized run against a reference model of outcomes, BHT and counters.
module tb_branch_resolve;
    localparam int IB = 6;
    localparam int FC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;

    branch_resolve_if bus();

    branch_resolve #(.INDEX_BITS(IB), .FLUSH_CYCLES(FC)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: counter values as plain integers 0..3.
    int          m_bht [1 << IB];
    logic [31:0] m_br, m_mis, m_rpc;

    typedef struct {
        logic [2:0] f3;
        logic [2:0] cmp;
        logic       pred;
        logic       exp_taken;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < (1 << IB); i++) m_bht[i] = 1;
        m_br = 0; m_mis = 0; m_rpc = 0;
    endfunction

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % (1 << IB));
    endfunction

    function automatic logic ref_taken(input logic [2:0] f3, input logic [2:0] cmp);
        logic eq, slt, ult;
        eq = cmp[2]; slt = cmp[1]; ult = cmp[0];
        case (f3)
            3'd0: return eq;
            3'd1: return !eq;
            3'd4: return slt;
            3'd5: return !slt;
            3'd6: return ult;
            3'd7: return !ult;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_branch(input logic [2:0] f3);
        return !(f3 == 3'd2 || f3 == 3'd3);
    endfunction

    task automatic check_pred(input logic [31:0] pc);
        bus.if_pc = pc;
        #1;
        check("pred_taken", {31'd0, bus.pred_taken}, {31'd0, m_bht[idx_of(pc)] >= 2});
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_br_count"}, bus.br_count, m_br);
        check({tag, "_mispred_count"}, bus.mispred_count, m_mis);
    endtask

    task automatic model_resolve(input logic [31:0] pc, input logic [31:0] imm,
                                 input logic pred, input logic taken);
        int i;
        i = idx_of(pc);
        if (taken) m_bht[i] = (m_bht[i] < 3) ? m_bht[i] + 1 : 3;
        else       m_bht[i] = (m_bht[i] > 0) ? m_bht[i] - 1 : 0;
        if (m_br != 32'hFFFF_FFFF) m_br++;
        if (taken != pred) begin
            if (m_mis != 32'hFFFF_FFFF) m_mis++;
            m_rpc = taken ? pc + imm : pc + 32'd4;
        end
    endtask

    // Called just after a falling edge with the block idle; returns just after a falling edge.
    task automatic do_branch(input logic [2:0] f3, input logic [2:0] cmp, input logic [31:0] pc,
                             input logic [31:0] imm, input logic pred, input logic exp_taken);
        logic misp;
        misp = is_branch(f3) && (exp_taken != pred);
        bus.br_valid = 1'b1; bus.br_funct3 = f3; bus.cmp_result = cmp;
        bus.br_pc = pc; bus.br_imm = imm; bus.br_pred_taken = pred;
        @(negedge clk);
        bus.br_valid = 1'b0;
        if (is_branch(f3)) model_resolve(pc, imm, pred, exp_taken);
        check("redirect_valid", {31'd0, bus.redirect_valid}, {31'd0, misp});
        check("redirect_pc", bus.redirect_pc, m_rpc);
        check("flush_first", {31'd0, bus.flush}, {31'd0, misp});
        check_stats("post");
        if (misp) begin
            repeat (FC - 1) begin
                @(negedge clk);
                check("flush_hold", {31'd0, bus.flush}, 32'd1);
                check("redirect_pulse_end", {31'd0, bus.redirect_valid}, 32'd0);
            end
            @(negedge clk);
            check("flush_done", {31'd0, bus.flush}, 32'd0);
        end
    endtask

    initial begin
        vec_t vecs [14];
        logic [31:0] pc, imm;
        logic [2:0]  f3, cmp;
        logic        pred;

        vecs[0]  = '{3'd0, 3'b100, 1'b1, 1'b1};
        vecs[1]  = '{3'd0, 3'b011, 1'b1, 1'b0};
        vecs[2]  = '{3'd1, 3'b100, 1'b0, 1'b0};
        vecs[3]  = '{3'd1, 3'b000, 1'b0, 1'b1};
        vecs[4]  = '{3'd4, 3'b010, 1'b0, 1'b1};
        vecs[5]  = '{3'd4, 3'b101, 1'b1, 1'b0};
        vecs[6]  = '{3'd5, 3'b010, 1'b1, 1'b0};
        vecs[7]  = '{3'd5, 3'b001, 1'b0, 1'b1};
        vecs[8]  = '{3'd6, 3'b001, 1'b1, 1'b1};
        vecs[9]  = '{3'd6, 3'b110, 1'b1, 1'b0};
        vecs[10] = '{3'd7, 3'b001, 1'b0, 1'b0};
        vecs[11] = '{3'd7, 3'b010, 1'b0, 1'b1};
        vecs[12] = '{3'd2, 3'b111, 1'b0, 1'b0};
        vecs[13] = '{3'd3, 3'b000, 1'b1, 1'b0};

        bus.if_pc = 0; bus.br_valid = 0; bus.br_funct3 = 0; bus.br_pc = 0;
        bus.br_imm = 0; bus.br_pred_taken = 0; bus.cmp_result = 0;
        model_reset();

        // Reset state
        #2;
        check("rst_redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
        check("rst_redirect_pc", bus.redirect_pc, 32'd0);
        check("rst_flush", {31'd0, bus.flush}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        check_stats("rst");
        @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a < 256; a += 4) check_pred(32'(a));

        // Taken-branch mispredict
        do_branch(3'd0, 3'b100, 32'h100, 32'h40, 1'b0, 1'b1);
        check("taken_rpc", bus.redirect_pc, 32'h140);
        check("taken_br_count", bus.br_count, 32'd1);
        check("taken_mis_count", bus.mispred_count, 32'd1);
        check_pred(32'h100);

        // Not-taken mispredict wrapping past 2^32
        do_branch(3'd6, 3'b000, 32'hFFFF_FFFC, 32'h20, 1'b1, 1'b0);
        check("wrap_rpc", bus.redirect_pc, 32'h0);

        // Wrong-path branch during flush is ignored
        bus.br_valid = 1'b1; bus.br_funct3 = 3'd0; bus.cmp_result = 3'b100;
        bus.br_pc = 32'h200; bus.br_imm = 32'h8; bus.br_pred_taken = 1'b0;
        @(negedge clk);
        model_resolve(32'h200, 32'h8, 1'b0, 1'b1);
        bus.br_funct3 = 3'd1; bus.cmp_result = 3'b000; bus.br_pc = 32'h300;
        bus.br_imm = 32'h10; bus.br_pred_taken = 1'b0;
        check("wp_first_redirect", {31'd0, bus.redirect_valid}, 32'd1);
        check("wp_rpc", bus.redirect_pc, 32'h208);
        repeat (FC - 1) begin
            @(negedge clk);
            check("wp_no_redirect", {31'd0, bus.redirect_valid}, 32'd0);
            check("wp_flush", {31'd0, bus.flush}, 32'd1);
            check_stats("wp");
        end
        bus.br_valid = 1'b0;
        @(negedge clk);
        check("wp_flush_done", {31'd0, bus.flush}, 32'd0);
        check("wp_no_redirect2", {31'd0, bus.redirect_valid}, 32'd0);
        check("wp_rpc_held", bus.redirect_pc, 32'h208);
        check_stats("wp_end");
        check_pred(32'h300);

        // Saturation: taken BGE five times, then a not-taken one drops 11 -> 10
        repeat (5) do_branch(3'd5, 3'b000, 32'h0000_0010, 32'h80, 1'b1, 1'b1);
        check_pred(32'h10);
        do_branch(3'd5, 3'b010, 32'h0000_0010, 32'h80, 1'b0, 1'b0);
        check_pred(32'h10);

        // Illegal funct3 has no effect
        do_branch(3'd2, 3'b000, 32'h10, 32'h4, 1'b1, 1'b0);
        check_pred(32'h10);

        // Vector table
        for (int v = 0; v < 14; v++) begin
            pc = 32'h1000 + 32'(v) * 32'h4;
            do_branch(vecs[v].f3, vecs[v].cmp, pc, 32'h0000_0100, vecs[v].pred, vecs[v].exp_taken);
            check_pred(pc);
        end

        // Randomized branches
        for (int n = 0; n < 200; n++) begin
            pc   = ($urandom() & 32'hFFFF_FF00) | (32'($urandom_range(0, 15)) << 2);
            imm  = $urandom() & 32'hFFFF_FFFE;
            f3   = 3'($urandom_range(0, 7));
            cmp  = 3'($urandom_range(0, 7));
            pred = ($urandom_range(0, 3) != 0) ? (m_bht[idx_of(pc)] >= 2) : 1'($urandom_range(0, 1));
            do_branch(f3, cmp, pc, imm, pred, ref_taken(f3, cmp));
            check_pred(32'($urandom_range(0, 63)) << 2);
        end

        // Asynchronous reset in the redirect cycle
        do_branch(3'd0, 3'b100, 32'h40, 32'h8, 1'b1, 1'b1);
        check_pred(32'h40);
        bus.br_valid = 1'b1; bus.br_funct3 = 3'd0; bus.cmp_result = 3'b100;
        bus.br_pc = 32'h40; bus.br_imm = 32'h8; bus.br_pred_taken = 1'b0;
        @(negedge clk);
        bus.br_valid = 1'b0;
        check("ar_redirect_before", {31'd0, bus.redirect_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("ar_flush", {31'd0, bus.flush}, 32'd0);
        check("ar_redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
        check("ar_redirect_pc", bus.redirect_pc, 32'd0);
        check_stats("ar");
        check_pred(32'h40);
        check_pred(32'h10);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ar_after_flush", {31'd0, bus.flush}, 32'd0);
        check("ar_after_redirect", {31'd0, bus.redirect_valid}, 32'd0);
        do_branch(3'd4, 3'b010, 32'h80, 32'h10, 1'b0, 1'b1);
        check("ar_after_rpc", bus.redirect_pc, 32'h90);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so a stuck run still ends with a report.
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
